// File: rtl/ram_responder_pkg.sv
// Shared types and constants for the CPU RAM responder: boot FSM states and
// the encoding of the CPU read/write strobe.
package ram_responder_pkg;

  typedef enum logic [1:0] {
    RR_CLEAR = 2'd0,
    RR_LOAD  = 2'd1,
    RR_RUN   = 2'd2
  } rr_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM, one registered read per cycle; a write returns
// the newly written word on the read port (write-first).
module ram_array #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 32768,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata_q   <= wdata;
    end else begin
      rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// CPU-facing RAM responder: zero-fills the RAM, loads a program image over a
// valid/ready port, then serves CPU reads/writes with a 1-cycle read latency.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 32768,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              wire_clock,
  input  logic              wire_reset,
  input  logic [ADDR_W-1:0] bus_RAM_ADDRESS,
  input  logic              wire_RW,
  input  logic [DATA_W-1:0] bus_RAM_DATA_IN,
  output logic [DATA_W-1:0] bus_RAM_DATA_OUT,
  output logic              wire_cpu_hold,
  input  logic [DATA_W-1:0] bus_LOAD_DATA,
  input  logic              wire_load_valid,
  input  logic              wire_load_last,
  output logic              wire_load_ready,
  output logic              wire_init_done,
  output logic              wire_range_err
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rr_state_t         state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              rerr_q, rerr_d;
  logic              rd_vld_q, rd_vld_d;

  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              in_range;

  // Full-width compare so out-of-range addresses never alias into the RAM.
  assign in_range = (ADDR_W+1)'(bus_RAM_ADDRESS) < (ADDR_W+1)'(DEPTH);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    done_d    = done_q;
    ready_d   = ready_q;
    rerr_d    = 1'b0;
    rd_vld_d  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = bus_RAM_ADDRESS[AW-1:0];
    ram_wdata = bus_RAM_DATA_IN;
    case (state_q)
      RR_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_wdata = '0;
        if (clr_cnt_q == LAST_IDX) begin
          state_d = RR_LOAD;
          ready_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      RR_LOAD: begin
        ram_addr  = ptr_q;
        ram_wdata = bus_LOAD_DATA;
        if (wire_load_valid && ready_q) begin
          ram_we = 1'b1;
          if (wire_load_last || ptr_q == LAST_IDX) begin
            state_d = RR_RUN;
            ready_d = 1'b0;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      RR_RUN: begin
        ram_we   = (wire_RW == RW_WRITE) && in_range;
        rd_vld_d = in_range;
        rerr_d   = !in_range;
      end
      default: state_d = RR_CLEAR;
    endcase
    if (wire_reset) ram_we = 1'b0;
  end

  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      state_q   <= CLEAR_ON_RESET ? RR_CLEAR : RR_LOAD;
      clr_cnt_q <= '0;
      ptr_q     <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      rerr_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      rerr_q    <= rerr_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  ram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (wire_clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Only in-range RUN reads expose RAM data; everything else reads as zero.
  assign bus_RAM_DATA_OUT = rd_vld_q ? ram_rdata : '0;
  assign wire_cpu_hold    = hold_q;
  assign wire_init_done   = done_q;
  assign wire_load_ready  = ready_q;
  assign wire_range_err   = rerr_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder at DEPTH=16: boot timing, image load,
// CPU read/write, range errors, pointer saturation and reset restart.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        rw;
  logic [15:0] din;
  logic [15:0] dout;
  logic        hold;
  logic [15:0] ld_data;
  logic        ld_valid;
  logic        ld_last;
  logic        ld_ready;
  logic        init_done;
  logic        range_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut (
    .wire_clock       (clk),
    .wire_reset       (rst),
    .bus_RAM_ADDRESS  (addr),
    .wire_RW          (rw),
    .bus_RAM_DATA_IN  (din),
    .bus_RAM_DATA_OUT (dout),
    .wire_cpu_hold    (hold),
    .bus_LOAD_DATA    (ld_data),
    .wire_load_valid  (ld_valid),
    .wire_load_last   (ld_last),
    .wire_load_ready  (ld_ready),
    .wire_init_done   (init_done),
    .wire_range_err   (range_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic w, input logic [15:0] a, input logic [15:0] d);
    rw = w; addr = a; din = d;
    step();
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    cpu(1'b0, a, 16'h0000);
    chk(tag, dout, exp);
  endtask

  task automatic load(input logic [15:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; rw = 1'b0; din = '0;
    ld_data = 16'h5555; ld_valid = 1'b1; ld_last = 1'b0;
    step();
    step();
    chk("rst_hold", hold, 1);
    chk("rst_ready", ld_ready, 0);
    chk("rst_done", init_done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rerr", range_err, 0);
    rst = 1'b0;

    // 1: CLEAR spans 16 cycles with valid held high, ready rises in cycle 17
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("clr_hold_%0d", i), hold, 1);
      chk($sformatf("clr_ready_%0d", i), ld_ready, 0);
      chk($sformatf("clr_done_%0d", i), init_done, 0);
      step();
    end
    chk("c17_ready", ld_ready, 1);
    chk("c17_hold", hold, 1);
    chk("c17_done", init_done, 0);

    // 2: three-word image, last on the third
    ld_data = 16'hC000; step();
    ld_data = 16'h0005; step();
    chk("ld_ready_mid", ld_ready, 1);
    ld_data = 16'hE000; ld_last = 1'b1; step();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("run_hold", hold, 0);
    chk("run_done", init_done, 1);
    chk("run_ready", ld_ready, 0);
    rd("rd0", 16'd0, 16'hC000);
    rd("rd1", 16'd1, 16'h0005);
    rd("rd2", 16'd2, 16'hE000);
    rd("rd7", 16'd7, 16'h0000);

    // 3: writes, write-first readback
    cpu(1'b1, 16'd4, 16'hBEEF);
    chk("wr4_wf", dout, 16'hBEEF);
    rd("rd4", 16'd4, 16'hBEEF);
    cpu(1'b1, 16'd4, 16'h1234);
    chk("wr4_wf2", dout, 16'h1234);
    rd("rd4b", 16'd4, 16'h1234);

    // 4: out-of-range accesses, including one whose low bits alias addr 4
    cpu(1'b1, 16'h0010, 16'hFFFF);
    chk("oor_rerr", range_err, 1);
    chk("oor_dout", dout, 0);
    rd("oor_rd0", 16'd0, 16'hC000);
    chk("oor_rerr_clr", range_err, 0);
    cpu(1'b1, 16'h0014, 16'hFFFF);
    chk("oor2_rerr", range_err, 1);
    cpu(1'b1, 16'h8004, 16'hFFFF);
    chk("oor3_rerr_persist", range_err, 1);
    chk("oor3_dout", dout, 0);
    rd("noalias_rd4", 16'd4, 16'h1234);
    chk("oor_rerr_end", range_err, 0);

    // 5: full 16-word image with valid gaps, no last
    reset_pulse();
    chk("r5_hold", hold, 1);
    chk("r5_ready", ld_ready, 0);
    chk("r5_done", init_done, 0);
    rd("r5_dout_masked", 16'd0, 16'h0000);
    repeat (15) step();
    chk("r5_ready_load", ld_ready, 1);
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      chk($sformatf("fill_ready_%0d", k), ld_ready, 1);
      load(16'h0100 + 16'(k), 1'b0);
    end
    chk("fill_done", init_done, 1);
    chk("fill_hold", hold, 0);
    chk("fill_ready_off", ld_ready, 0);
    ld_valid = 1'b1; ld_data = 16'hDEAD;
    step();
    chk("w17_ready", ld_ready, 0);
    ld_valid = 1'b0;
    rd("fill_rd15", 16'd15, 16'h010F);
    rd("fill_rd0", 16'd0, 16'h0100);
    rd("fill_rd9", 16'd9, 16'h0109);

    // 6: reset mid-load restarts boot and clears the RAM
    reset_pulse();
    repeat (15) step();
    load(16'hAAAA, 1'b0);
    load(16'hBBBB, 1'b0);
    chk("r6_pre_done", init_done, 0);
    reset_pulse();
    chk("r6_hold", hold, 1);
    chk("r6_ready", ld_ready, 0);
    repeat (15) step();
    chk("r6_c16_ready", ld_ready, 0);
    step();
    chk("r6_c17_ready", ld_ready, 1);
    load(16'h1111, 1'b1);
    chk("r6_done", init_done, 1);
    chk("r6_run_hold", hold, 0);
    rd("r6_rd0", 16'd0, 16'h1111);
    rd("r6_rd1", 16'd1, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the CPU RAM bus. It serves the CPU's address, read/write and data signals from an internal single-port RAM with a 1-cycle registered read.
- Before the CPU runs, an internal boot sequence runs: it clears the RAM, then accepts a program image over a valid/ready loader port.
- While the boot sequence runs, wire_cpu_hold holds the CPU.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, CPU address width.
- DEPTH, 32768, number of RAM words. Must be a power of 2 and at most 2**ADDR_W.
- CLEAR_ON_RESET, 1, selects the first state after reset: 1 = zero-fill RAM first, 0 = go directly to LOAD.

Ports:
- wire_clock  in  1  single clock; all logic runs on its rising edge.
- wire_reset  in  1  reset, synchronous and active-high.
- bus_RAM_ADDRESS  in  ADDR_W  CPU word address.
- wire_RW  in  1  CPU access type: 0 = read, 1 = write.
- bus_RAM_DATA_IN  in  DATA_W  write data from the CPU.
- bus_RAM_DATA_OUT  out  DATA_W  registered read data to the CPU.
- wire_cpu_hold  out  1  1 = CPU must stall; RAM is not being served to the CPU.
- bus_LOAD_DATA  in  DATA_W  loader word.
- wire_load_valid  in  1  loader word present.
- wire_load_last  in  1  the present loader word is the final word of the image.
- wire_load_ready  out  1  responder accepts a loader word this cycle.
- wire_init_done  out  1  boot complete; RUN state.
- wire_range_err  out  1  1-cycle pulse on a CPU access with address >= DEPTH.

Behaviour:
- Reset is synchronous: wire_reset sampled high at a rising edge wins over every other event.
- Reset values:
  - bus_RAM_DATA_OUT = 0.
  - wire_cpu_hold = 1.
  - wire_load_ready = 0.
  - wire_init_done = 0.
  - wire_range_err = 0.
  - Clear counter and load pointer = 0.
  - State = CLEAR if CLEAR_ON_RESET, else LOAD.
- States are CLEAR, LOAD and RUN. No other transitions exist; only reset leaves RUN.
- CLEAR:
  - Writes 0 to RAM[cnt] each cycle, cnt = 0..DEPTH-1.
  - After the write of DEPTH-1, moves to LOAD. CLEAR lasts exactly DEPTH cycles.
  - CPU signals and loader signals are ignored. wire_load_ready = 0.
- LOAD:
  - wire_load_ready = 1 in every LOAD cycle, including the first.
  - A transfer happens when valid && ready at the edge: RAM[ptr] <= bus_LOAD_DATA, then ptr++.
  - LOAD moves to RUN on the edge of a transfer with wire_load_last = 1, or of a transfer with ptr == DEPTH-1. ptr never wraps.
  - wire_load_ready drops to 0 in the first RUN cycle.
  - valid gaps are allowed; there is no timeout.
  - CPU signals are ignored. bus_RAM_DATA_OUT holds 0.
- RUN:
  - wire_cpu_hold = 0 and wire_init_done = 1, both registered, starting the cycle after the transition.
  - Read: the address sampled at edge N appears on bus_RAM_DATA_OUT after edge N and is valid during cycle N+1.
  - Write: if wire_RW = 1 and address < DEPTH, RAM[addr] <= bus_RAM_DATA_IN at the edge.
  - Same-cycle write and read of the same address is write-first: bus_RAM_DATA_OUT returns the new data.
  - Address >= DEPTH:
    - A write is dropped.
    - bus_RAM_DATA_OUT <= 0.
    - wire_range_err = 1 for the following cycle only; it is re-asserted each cycle the condition persists.
  - Loader inputs are ignored.
- Address compare uses the full ADDR_W bits; there is no aliasing.
- Reset during CLEAR, LOAD or RUN restarts the boot sequence. Contents from before the reset are lost if CLEAR_ON_RESET = 1.

Decomposition:
- ram_responder_pkg holds:
  - typedef enum logic [1:0] rr_state_t {RR_CLEAR, RR_LOAD, RR_RUN}.
  - Constants RW_READ = 1'b0 and RW_WRITE = 1'b1.
- Sub-module ram_array (parameters DATA_W, DEPTH):
  - Single-port synchronous RAM.
  - Inputs: we, addr, wdata. Output: registered rdata, write-first.
- The parent contains:
  - The FSM.
  - The clear counter and load pointer.
  - The port mux selecting clear, load or CPU.
  - The range check and the output zeroing.

Test Plan (DEPTH = 16, CLEAR_ON_RESET = 1 unless stated):
1. Release reset; hold valid = 1 throughout. Required response:
   - wire_cpu_hold = 1 and wire_load_ready = 0 for 16 cycles.
   - wire_load_ready = 1 in cycle 17.
   - wire_init_done = 0 throughout.
2. Load 0xC000, 0x0005, 0xE000 with last on the third word. Then read addresses 0, 1, 2 and 7. Required response:
   - Next cycle: wire_cpu_hold = 0, wire_init_done = 1, wire_load_ready = 0.
   - Reads return 0xC000, 0x0005, 0xE000 and 0x0000, each one cycle after its address.
3. Write: RW=1, addr 4, data 0xBEEF, then read addr 4 → 0xBEEF. Same-cycle write 0x1234 to addr 4 → bus_RAM_DATA_OUT = 0x1234 next cycle.
4. Access addr 0x0010 with RW=1, data 0xFFFF. Required response:
   - wire_range_err pulses for 1 cycle.
   - bus_RAM_DATA_OUT = 0x0000.
   - A subsequent read of addr 0 returns its prior value.
5. Load 16 words 0x0100..0x010F with random valid gaps and last never set. Required response:
   - RUN is entered after the 16th transfer.
   - A 17th valid word sees ready = 0 and is not written.
   - Addr 15 reads 0x010F.
6. After loading 0xAAAA and 0xBBBB, assert reset for 1 cycle. Required response:
   - Next cycle: hold = 1, ready = 0.
   - After the 16-cycle CLEAR, load 0x1111 with last set; then addr 0 reads 0x1111 and addr 1 reads 0x0000.
